rr_mux_arb: RTL

Parametrised round-robin arbitrating multiplexer: selects one of `NCH` valid/ready input channels of `W` bits each and forwards it through a single registered output stage. It succeeds the fixed-select combinational muxes and the 3-to-8 decoder in the logic library. Selection is internal, fair and handshake-driven rather than an external `sel` input. It sits between multiple producers and one shared consumer (bus, FIFO or serialiser).

---
 rtl/rr_mux_arb_if.sv | 65 ++++++
 rtl/rr_mux_arb.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rr_mux_arb_if.sv
// -----------------------------------------------------------------------------
// rr_mux_arb_if
// Bundles the handshake and data signals of the round-robin arbitrating mux.
//
// Signals:
//   en         arbitration enable (low blocks new grants, output still drains)
//   in_data    NCH*W  channel i at [i*W +: W]
//   in_valid   NCH    per-channel request
//   in_ready   NCH    per-channel accept, one-hot or zero
//   out_data   W      registered selected word
//   out_sel    SW     index of the channel held in out_data
//   out_valid  1      output register holds a word
//   out_ready  1      consumer accepts the output word
//   out_grant  NCH    one-hot copy of out_sel (only with RR_MUX_ONEHOT_EN)
//
// Modports:
//   slave   the arbiter itself
//   master  the environment: producers on the input side, consumer on the output
// -----------------------------------------------------------------------------
interface rr_mux_arb_if #(
    parameter int NCH = 4,
    parameter int W   = 8
);
    localparam int SW = $clog2(NCH);

    logic             en;
    logic [NCH*W-1:0] in_data;
    logic [NCH-1:0]   in_valid;
    logic [NCH-1:0]   in_ready;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_sel;
    logic             out_valid;
    logic             out_ready;
`ifdef RR_MUX_ONEHOT_EN
    logic [NCH-1:0]   out_grant;
`endif

    modport slave (
        input  en,
        input  in_data,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_sel,
        output out_valid,
`ifdef RR_MUX_ONEHOT_EN
        output out_grant,
`endif
        input  out_ready
    );

    modport master (
        output en,
        output in_data,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_sel,
        input  out_valid,
`ifdef RR_MUX_ONEHOT_EN
        input  out_grant,
`endif
        output out_ready
    );
endinterface

// File: rtl/rr_mux_arb.sv
// -----------------------------------------------------------------------------
// rr_mux_arb
// Round-robin arbitrating multiplexer. Picks one of NCH valid/ready input
// channels, starting the search at a rotating pointer, and forwards the chosen
// word through a single registered output stage with full back-to-back
// throughput.
//
// Parameters:
//   NCH  number of input channels (>= 2, any value)
//   W    data width per channel (>= 1)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_mux_arb_if.slave (en, in_data/in_valid/in_ready,
//          out_data/out_sel/out_valid/out_ready, optional out_grant)
//
// Optional feature macro: RR_MUX_ONEHOT_EN
//   When defined, adds the registered one-hot out_grant output, loaded on every
//   input transfer, cleared by reset and held after out_valid falls.
// -----------------------------------------------------------------------------
module rr_mux_arb #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    rr_mux_arb_if.slave bus
);
    localparam int SW = $clog2(NCH);

    // Pointer offset add that wraps modulo NCH without a divider; works for
    // non-power-of-two NCH since base < NCH and k < NCH.
    function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NCH) begin
            s = s - NCH;
        end
        return SW'(s);
    endfunction

    logic [SW-1:0]  ptr_q,       ptr_d;
    logic [W-1:0]   out_data_q,  out_data_d;
    logic [SW-1:0]  out_sel_q,   out_sel_d;
    logic           out_valid_q, out_valid_d;
`ifdef RR_MUX_ONEHOT_EN
    logic [NCH-1:0] out_grant_q, out_grant_d;
`endif

    logic           grant_found;
    logic [SW-1:0]  grant_idx;
    logic [W-1:0]   grant_data;
    logic           load;
    logic           xfer_in;
    logic [NCH-1:0] in_ready_w;

    // Rotating-priority search: first requester at ptr, ptr+1, ... wrapping.
    always_comb begin
        logic [SW-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = wrap_idx(ptr_q, k);
            if (!grant_found && bus.in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Data mux for the winning channel.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SW'(i) == grant_idx) begin
                grant_data = bus.in_data[i*W +: W];
            end
        end
    end

    // rst_n gates load so in_ready is forced low while reset is held, even
    // though the output register is already empty.
    always_comb begin
        load       = rst_n && bus.en && (!out_valid_q || bus.out_ready);
        xfer_in    = load && grant_found;
        in_ready_w = '0;
        if (xfer_in) begin
            in_ready_w[grant_idx] = 1'b1;
        end
    end

    // Next-state: reload on input transfer (also covers the simultaneous
    // drain+reload case), otherwise empty the register when the word leaves.
    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
`ifdef RR_MUX_ONEHOT_EN
        out_grant_d = out_grant_q;
`endif
        if (xfer_in) begin
            out_data_d  = grant_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = (grant_idx == SW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
`ifdef RR_MUX_ONEHOT_EN
            out_grant_d = '0;
            out_grant_d[grant_idx] = 1'b1;
`endif
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
`ifdef RR_MUX_ONEHOT_EN
            out_grant_q <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
`ifdef RR_MUX_ONEHOT_EN
            out_grant_q <= out_grant_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
`ifdef RR_MUX_ONEHOT_EN
    assign bus.out_grant = out_grant_q;
`endif

endmodule
